// File: rtl/seg7_scan_driver_if.sv
// Bus between the datapath and the 7-segment scan driver.
//   load/data/dp_in/digit_en/lz_suppress : frame written by the datapath (master)
//   an_n/seg_n/dp_n/frame_done            : display pins and frame strobe (slave)
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   data;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     digit_en;
  logic                    lz_suppress;
  logic [N_DIGITS-1:0]     an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output load, data, dp_in, digit_en, lz_suppress,
    input  an_n, seg_n, dp_n, frame_done
  );

  modport slave (
    input  load, data, dp_in, digit_en, lz_suppress,
    output an_n, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seg7_scan_driver_if (frame inputs, an_n/seg_n/dp_n/frame_done)
// One digit is lit per REFRESH_DIV-cycle slot; anodes stay off for the first GUARD_CYCLES of
// each slot. All outputs are registered (one cycle behind the scan state).
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned HEX_MODE     = 0
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int unsigned     DivW     = $clog2(REFRESH_DIV);
  localparam int unsigned     IdxW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(N_DIGITS - 1);
  localparam logic [DivW-1:0] GuardCnt = DivW'(GUARD_CYCLES);
  localparam bit              Hex      = (HEX_MODE != 0);

  logic [DivW-1:0] div_q, div_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            slot_end, frame_end;

  logic [N_DIGITS-1:0][3:0] pend_data_q, act_data_q, in_data;
  logic [N_DIGITS-1:0]      pend_dp_q, act_dp_q, pend_en_q, act_en_q;
  logic                     pend_lz_q, act_lz_q;

  logic [N_DIGITS-1:0] supp;
  logic [3:0]          cur_code;
  logic                cur_dark, cur_blank;
  logic [N_DIGITS-1:0] an_d, an_q;
  logic [6:0]          seg_d, seg_q;
  logic                dp_d, dp_q, fd_d, fd_q;

  assign in_data = bus.data;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = Hex ? 7'h08 : 7'h06;
      4'hB:    s = Hex ? 7'h03 : 7'h06;
      4'hC:    s = Hex ? 7'h46 : 7'h06;
      4'hD:    s = Hex ? 7'h21 : 7'h06;
      4'hE:    s = 7'h06;
      default: s = Hex ? 7'h0E : 7'h7F;
    endcase
    return s;
  endfunction

  // Scan counters
  always_comb begin
    slot_end  = (div_q == DivLast);
    frame_end = slot_end && (idx_q == IdxLast);
    div_d     = slot_end ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    // Registered from next state so the pulse lines up with the last cycle of the frame.
    fd_d      = (div_d == DivLast) && (idx_d == IdxLast);
  end

  // Leading-zero run scanned from the most significant digit down; a lit dp ends it.
  always_comb begin
    logic run;
    run  = 1'b1;
    supp = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      if (act_lz_q && run && (act_data_q[k] == 4'h0) && !act_dp_q[k] && (k != 0)) begin
        supp[k] = 1'b1;
      end
      run = run && ((act_data_q[k] == 4'h0) || !act_en_q[k]) && !act_dp_q[k];
    end
  end

  always_comb begin
    cur_code  = act_data_q[idx_q];
    cur_dark  = !act_en_q[idx_q] || supp[idx_q];
    cur_blank = cur_dark || (!Hex && (cur_code == 4'hF));
    seg_d     = cur_blank ? 7'h7F : decode(cur_code);
    dp_d      = cur_blank ? 1'b1 : !act_dp_q[idx_q];
    an_d      = '1;
    // Code-F blanks still select their anode; only dark digits and the guard keep it off.
    if (!cur_dark && !(div_q < GuardCnt)) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= {N_DIGITS{4'hF}};
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_lz_q   <= 1'b0;
      act_data_q  <= {N_DIGITS{4'hF}};
      act_dp_q    <= '0;
      act_en_q    <= '0;
      act_lz_q    <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      if (bus.load) begin
        pend_data_q <= in_data;
        pend_dp_q   <= bus.dp_in;
        pend_en_q   <= bus.digit_en;
        pend_lz_q   <= bus.lz_suppress;
      end
      if (frame_end) begin
        // A load on the frame boundary bypasses pending so it shows in the very next frame.
        act_data_q <= bus.load ? in_data         : pend_data_q;
        act_dp_q   <= bus.load ? bus.dp_in       : pend_dp_q;
        act_en_q   <= bus.load ? bus.digit_en    : pend_en_q;
        act_lz_q   <= bus.load ? bus.lz_suppress : pend_lz_q;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.an_n       = an_q;
  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int unsigned ND = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver_if #(.N_DIGITS(ND)) bus0 ();
  seg7_scan_driver_if #(.N_DIGITS(ND)) bus1 ();

  seg7_scan_driver #(
    .N_DIGITS(ND), .REFRESH_DIV(4), .GUARD_CYCLES(1), .HEX_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  seg7_scan_driver #(
    .N_DIGITS(ND), .REFRESH_DIV(4), .GUARD_CYCLES(1), .HEX_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] en, input logic lz);
    bus0.load = ld; bus0.data = d; bus0.dp_in = dp; bus0.digit_en = en; bus0.lz_suppress = lz;
    bus1.load = ld; bus1.data = d; bus1.dp_in = dp; bus1.digit_en = en; bus1.lz_suppress = lz;
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                            input logic lz);
    drive(1'b1, d, dp, en, lz);
    @(posedge clk);
    #1;
    bus0.load = 1'b0;
    bus1.load = 1'b0;
  endtask

  // Returns just after the posedge that closes the frame_done cycle.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus0.frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " frame_done seen"}, 32'(bus0.frame_done), 32'd1);
    @(posedge clk);
  endtask

  // Checks one full frame starting at a frame boundary; ends on the next boundary.
  // Vectors are indexed by digit; dp0/dp1 are expected dp_n values.
  task automatic run_frame(input string tag, input logic [3:0][6:0] s0,
                           input logic [3:0][6:0] s1, input logic [3:0] dp0,
                           input logic [3:0] dp1, input logic [3:0] dark, input int load_at,
                           input logic [15:0] ld_d, input logic [3:0] ld_dp,
                           input logic [3:0] ld_en, input logic ld_lz);
    int s, c;
    logic [3:0] ea;
    for (int k = 0; k < 16; k++) begin
      s = k / 4;
      c = k % 4;
      @(posedge clk);
      @(negedge clk);
      ea = 4'hF;
      if (c != 0 && !dark[s]) ea[s] = 1'b0;
      check($sformatf("%s s%0d c%0d an0", tag, s, c), 32'(bus0.an_n), 32'(ea));
      check($sformatf("%s s%0d c%0d an1", tag, s, c), 32'(bus1.an_n), 32'(ea));
      check($sformatf("%s s%0d c%0d seg0", tag, s, c), 32'(bus0.seg_n), 32'(s0[s]));
      check($sformatf("%s s%0d c%0d seg1", tag, s, c), 32'(bus1.seg_n), 32'(s1[s]));
      check($sformatf("%s s%0d c%0d dp0", tag, s, c), 32'(bus0.dp_n), 32'(dp0[s]));
      check($sformatf("%s s%0d c%0d dp1", tag, s, c), 32'(bus1.dp_n), 32'(dp1[s]));
      check($sformatf("%s s%0d c%0d fd", tag, s, c), 32'(bus0.frame_done), 32'(k == 14));
      if (k == load_at) drive(1'b1, ld_d, ld_dp, ld_en, ld_lz);
      else begin
        bus0.load = 1'b0;
        bus1.load = 1'b0;
      end
    end
  endtask

  initial begin
    int first_fd, second_fd, n;
    logic idle_ok;
    drive(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);

    // Reset values
    #12;
    check("rst an0", 32'(bus0.an_n), 32'hF);
    check("rst seg0", 32'(bus0.seg_n), 32'h7F);
    check("rst dp0", 32'(bus0.dp_n), 32'h1);
    check("rst fd0", 32'(bus0.frame_done), 32'h0);
    check("rst an1", 32'(bus1.an_n), 32'hF);
    check("rst seg1", 32'(bus1.seg_n), 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: dark display, frame_done on cycles 15 and 31
    first_fd = -1; second_fd = -1; idle_ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus0.an_n !== 4'hF || bus0.seg_n !== 7'h7F || bus1.seg_n !== 7'h7F) idle_ok = 1'b0;
      if (bus0.frame_done === 1'b1) begin
        if (first_fd < 0) first_fd = k;
        else if (second_fd < 0) second_fd = k;
      end
    end
    check("idle dark", 32'(idle_ok), 32'd1);
    check("idle first fd", 32'(first_fd), 32'd15);
    check("idle second fd", 32'(second_fd), 32'd31);

    // Plain digits 1234
    load_pulse(16'h1234, 4'h0, 4'hF, 1'b0);
    wait_frame("t2");
    run_frame("t2", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19},
              4'hF, 4'hF, 4'h0, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // Leading-zero suppression
    load_pulse(16'h0070, 4'h0, 4'hF, 1'b1);
    wait_frame("t3a");
    run_frame("t3a", {7'h7F, 7'h7F, 7'h78, 7'h40}, {7'h7F, 7'h7F, 7'h78, 7'h40},
              4'hF, 4'hF, 4'b1100, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    load_pulse(16'h0070, 4'b0100, 4'hF, 1'b1);
    wait_frame("t3b");
    run_frame("t3b", {7'h7F, 7'h40, 7'h78, 7'h40}, {7'h7F, 7'h40, 7'h78, 7'h40},
              4'b1011, 4'b1011, 4'b1000, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // BCD vs hex glyphs; code F blank in BCD keeps its anode but drops dp.
    // A mid-frame load of 8642 must not disturb this frame.
    load_pulse(16'hCFA5, 4'b0100, 4'hF, 1'b0);
    wait_frame("t4");
    run_frame("t4", {7'h06, 7'h7F, 7'h06, 7'h12}, {7'h46, 7'h0E, 7'h08, 7'h12},
              4'hF, 4'b1011, 4'h0, 5, 16'h8642, 4'h0, 4'hF, 1'b0);
    // 8642 shows now; load 0909 exactly on the frame_done cycle
    run_frame("t5a", {7'h00, 7'h02, 7'h19, 7'h24}, {7'h00, 7'h02, 7'h19, 7'h24},
              4'hF, 4'hF, 4'h0, 14, 16'h0909, 4'h0, 4'b1101, 1'b0);
    run_frame("t5b", {7'h40, 7'h10, 7'h7F, 7'h10}, {7'h40, 7'h10, 7'h7F, 7'h10},
              4'hF, 4'hF, 4'b0010, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // Asynchronous reset in slot 2
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t6 pre-reset an0", 32'(bus0.an_n), 32'b1011);
    rst_n = 1'b0;
    #1;
    check("t6 async an0", 32'(bus0.an_n), 32'hF);
    check("t6 async seg0", 32'(bus0.seg_n), 32'h7F);
    check("t6 async dp0", 32'(bus0.dp_n), 32'h1);
    check("t6 async seg1", 32'(bus1.seg_n), 32'h7F);
    repeat (2) @(posedge clk);
    #1;
    check("t6 held an0", 32'(bus0.an_n), 32'hF);
    check("t6 held fd0", 32'(bus0.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h5678, 4'b0001, 4'hF, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      bus0.load = 1'b0;
      bus1.load = 1'b0;
      @(negedge clk);
      n++;
    end while (bus0.frame_done !== 1'b1 && n < 40);
    check("t6 first fd after release", 32'(n), 32'd15);
    @(posedge clk);
    run_frame("t6", {7'h12, 7'h02, 7'h78, 7'h00}, {7'h12, 7'h02, 7'h78, 7'h00},
              4'b1110, 4'b1110, 4'h0, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
